// File: rtl/rr_arbiter8_pkg.sv
// Shared types and widths for the eight-way round-robin arbiter.
package rr_arbiter8_pkg;

    localparam int unsigned N_REQ    = 8;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned DEC_IN_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter8_dec.sv
// 3-to-8 decoder with a 4-bit select; selects above 7 decode to all-zero.
module decoder3_8
    import rr_arbiter8_pkg::*;
(
    input  logic [DEC_IN_W-1:0] sel,
    output logic [N_REQ-1:0]    dec_c
);

    always_comb begin
        dec_c = '0;
        if (!sel[DEC_IN_W-1]) begin
            dec_c[sel[IDX_W-1:0]] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter holding one grant until done, request drop or hold limit.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy,
    output logic             timeout
);

    localparam int unsigned          HOLD_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam bit                   HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt;
    logic [IDX_W-1:0]  idx_nxt;
    logic [HOLD_W-1:0] hold, hold_nxt;
    logic              timeout_nxt;
    logic [N_REQ-1:0]  dec_c;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [IDX_W-1:0]   pe;
        dbl = {r, r};
        rot = N_REQ'(dbl >> p);
        pe  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) pe = IDX_W'(i);
        end
        return pe + p;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
            hold    <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gnt_idx <= idx_nxt;
            hold    <= hold_nxt;
            timeout <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        idx_nxt     = gnt_idx;
        hold_nxt    = hold;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    idx_nxt   = rr_pick(req, ptr);
                    ptr_nxt   = idx_nxt + IDX_W'(1);
                    hold_nxt  = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // Release priority: done, owner drop, then hold limit.
                if (done || !req[gnt_idx]) begin
                    state_nxt = IDLE;
                end else if (HOLD_EN && (hold == HOLD_LAST)) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end else if (HOLD_EN) begin
                    hold_nxt = hold + HOLD_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == GRANT);

    decoder3_8 u_dec (
        .sel   (DEC_IN_W'(gnt_idx)),
        .dec_c (dec_c)
    );

    assign gnt = dec_c & {N_REQ{busy}};

endmodule
